// File: rtl/regs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regs_pkg
//  Description : Types and helpers shared by the serial shift register
//                blocks: output-buffer state encoding and the bit-counter
//                width derivation used by the transmitter and receiver.
//  Revision    : 1.0  initial release
// ============================================================================
package regs_pkg;

    // Single-entry output buffer occupancy.
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    // Counter width needed to index WIDTH bit positions (never below 1).
    function automatic int cnt_width(input int width);
        int n;
        n = 0;
        while ((1 << n) < width) begin
            n = n + 1;
        end
        return (n < 1) ? 1 : n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/deser_out_buf.sv
`default_nettype none
// ============================================================================
//  Module      : deser_out_buf
//  Description : One-entry valid/ready holding register. A word offered while
//                the entry is occupied and not being consumed is dropped and
//                raises a sticky overrun flag.
//  Revision    : 1.0  initial release
// ============================================================================
module deser_out_buf
    import regs_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    input  logic             clr_overrun,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             overrun
);

    buf_state_t       r_state;
    buf_state_t       w_state_next;
    logic             w_load_en;
    logic             w_drop;
    logic [WIDTH-1:0] r_data;
    logic             r_overrun;

    // Buffer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, load and drop decisions; a consume in the same cycle as a
    // new word frees the slot, so the new word is taken without overrun.
    always_comb begin
        w_state_next = r_state;
        w_load_en    = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            BUF_EMPTY: begin
                if (load) begin
                    w_load_en    = 1'b1;
                    w_state_next = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (load) begin
                    if (ready) begin
                        w_load_en = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                end else if (ready) begin
                    w_state_next = BUF_EMPTY;
                end
            end
            default: begin
                w_state_next = BUF_EMPTY;
            end
        endcase
    end

    // Held word; only changes when a new word is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (w_load_en) begin
            r_data <= load_data;
        end
    end

    // Sticky overrun; a new drop beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign valid   = (r_state == BUF_FULL);
    assign data    = r_data;
    assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/shift_deserializer_right.sv
`default_nettype none
// ============================================================================
//  Module      : shift_deserializer_right
//  Description : LSB-first serial-to-parallel receiver. Bits enter at the MSB
//                of a shift register and move right; after WIDTH bits the
//                first bit received sits in bit 0. Completed words are handed
//                to a one-entry valid/ready buffer with sticky overrun.
//  Revision    : 1.0  initial release
// ============================================================================
module shift_deserializer_right
    import regs_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             serial_in,
    input  logic             frame_start,
    input  logic             clr_overrun,
    input  logic             word_ready,
    output logic             word_valid,
    output logic [WIDTH-1:0] word_data,
    output logic [CNT_W-1:0] bit_count,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_bit_count;
    logic [WIDTH-1:0] w_shift_word;
    logic             w_complete;

    // The shifted value doubles as the candidate word on the final bit, so
    // the word is presented to the buffer on the same edge that samples it.
    assign w_shift_word = {serial_in, r_shreg[WIDTH-1:1]};
    assign w_complete   = bit_valid && !frame_start && (r_bit_count == c_last_bit);

    // Shift register and bit counter; frame_start realigns the word boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg     <= '0;
            r_bit_count <= '0;
        end else if (frame_start) begin
            if (bit_valid) begin
                r_shreg     <= w_shift_word;
                r_bit_count <= CNT_W'(1);
            end else begin
                r_bit_count <= '0;
            end
        end else if (bit_valid) begin
            r_shreg <= w_shift_word;
            if (w_complete) begin
                r_bit_count <= '0;
            end else begin
                r_bit_count <= r_bit_count + 1'b1;
            end
        end
    end

    deser_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk         (clk),
        .rst         (rst),
        .load        (w_complete),
        .load_data   (w_shift_word),
        .ready       (word_ready),
        .clr_overrun (clr_overrun),
        .valid       (word_valid),
        .data        (word_data),
        .overrun     (overrun)
    );

    assign bit_count = r_bit_count;

endmodule
`default_nettype wire

// File: tb/tb_shift_deserializer_right.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_deserializer_right
//  Description : Directed self-checking bench for shift_deserializer_right
//                (WIDTH=8), including a loopback against a behavioural
//                right-shift PISO transmitter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_deserializer_right;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst;
    logic             bit_valid;
    logic             serial_in;
    logic             frame_start;
    logic             clr_overrun;
    logic             word_ready;
    logic             word_valid;
    logic [WIDTH-1:0] word_data;
    logic [CNT_W-1:0] bit_count;
    logic             overrun;

    int total;
    int bad;

    shift_deserializer_right #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bit_valid   (bit_valid),
        .serial_in   (serial_in),
        .frame_start (frame_start),
        .clr_overrun (clr_overrun),
        .word_ready  (word_ready),
        .word_valid  (word_valid),
        .word_data   (word_data),
        .bit_count   (bit_count),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bit_valid   = 1'b0;
        serial_in   = 1'b0;
        frame_start = 1'b0;
        clr_overrun = 1'b0;
        word_ready  = 1'b0;
    endtask

    // Send one word LSB first; rdy[i] is word_ready on the cycle bit i is sampled.
    task automatic send_word(input logic [7:0] w, input logic [7:0] rdy);
        for (int i = 0; i < 8; i++) begin
            bit_valid  = 1'b1;
            serial_in  = w[i];
            word_ready = rdy[i];
            tick();
        end
        bit_valid  = 1'b0;
        word_ready = 1'b0;
    endtask

    task automatic drain();
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (word_valid !== 1'b0 || word_data !== 8'h00 || bit_count !== 3'd0 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset: valid=%b data=%h count=%0d ovr=%b, required 0/00/0/0",
                     word_valid, word_data, bit_count, overrun);
        end
    endtask

    task automatic test_single_word();
        send_word(8'hA5, 8'hFF);
        total++;
        if (word_valid !== 1'b1 || word_data !== 8'hA5 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL single_word: valid=%b data=%h ovr=%b, required 1/a5/0",
                     word_valid, word_data, overrun);
        end
        total++;
        if (bit_count !== 3'd0) begin
            bad++;
            $display("FAIL single_count_wrap: count=%0d, required 0", bit_count);
        end
        drain();
        total++;
        if (word_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_drain: valid=%b, required 0", word_valid);
        end
    endtask

    task automatic test_overrun();
        send_word(8'h3C, 8'h00);
        total++;
        if (word_valid !== 1'b1 || word_data !== 8'h3C || overrun !== 1'b0) begin
            bad++;
            $display("FAIL ovr_first: valid=%b data=%h ovr=%b, required 1/3c/0",
                     word_valid, word_data, overrun);
        end
        send_word(8'hC3, 8'h00);
        total++;
        if (word_valid !== 1'b1 || word_data !== 8'h3C || overrun !== 1'b1) begin
            bad++;
            $display("FAIL ovr_drop: valid=%b data=%h ovr=%b, required 1/3c/1",
                     word_valid, word_data, overrun);
        end
        // Idle cycles with an unknown serial line must not disturb anything.
        serial_in = 1'bx;
        tick();
        tick();
        serial_in = 1'b0;
        total++;
        if ($isunknown({word_valid, word_data, bit_count, overrun}) || overrun !== 1'b1) begin
            bad++;
            $display("FAIL x_isolation: valid=%b data=%h count=%b ovr=%b, required known, ovr=1",
                     word_valid, word_data, bit_count, overrun);
        end
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        total++;
        if (overrun !== 1'b0 || word_valid !== 1'b1 || word_data !== 8'h3C) begin
            bad++;
            $display("FAIL ovr_clear: ovr=%b valid=%b data=%h, required 0/1/3c",
                     overrun, word_valid, word_data);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        send_word(8'h3C, 8'h00);
        send_word(8'hC3, 8'h80);
        total++;
        if (word_valid !== 1'b1 || word_data !== 8'hC3 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL back_to_back: valid=%b data=%h ovr=%b, required 1/c3/0",
                     word_valid, word_data, overrun);
        end
        drain();
        total++;
        if (word_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain: valid=%b, required 0", word_valid);
        end
    endtask

    task automatic test_frame_start();
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1;
            serial_in = 1'b1;
            tick();
        end
        frame_start = 1'b1;
        serial_in   = 1'b1;
        tick();
        frame_start = 1'b0;
        total++;
        if (bit_count !== 3'd1) begin
            bad++;
            $display("FAIL frame_count: count=%0d, required 1", bit_count);
        end
        for (int i = 0; i < 7; i++) begin
            serial_in = 1'b0;
            tick();
            if (i == 4) begin
                total++;
                if (word_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL frame_partial: valid=%b, required 0", word_valid);
                end
            end
        end
        bit_valid = 1'b0;
        total++;
        if (word_valid !== 1'b1 || word_data !== 8'h01) begin
            bad++;
            $display("FAIL frame_word: valid=%b data=%h, required 1/01", word_valid, word_data);
        end
        drain();
        // frame_start without a bit clears the count and shifts nothing.
        bit_valid = 1'b1;
        serial_in = 1'b1;
        tick();
        tick();
        bit_valid   = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        total++;
        if (bit_count !== 3'd0 || word_valid !== 1'b0) begin
            bad++;
            $display("FAIL frame_idle: count=%0d valid=%b, required 0/0", bit_count, word_valid);
        end
    endtask

    task automatic test_reset_abort();
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1;
            serial_in = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (bit_count !== 3'd0 || word_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_count: count=%0d valid=%b, required 0/0", bit_count, word_valid);
        end
        for (int i = 0; i < 7; i++) begin
            bit_valid = 1'b1;
            serial_in = 1'b1;
            tick();
        end
        total++;
        if (word_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_residue: valid=%b after 7 bits, required 0", word_valid);
        end
        tick();
        bit_valid = 1'b0;
        total++;
        if (word_valid !== 1'b1 || word_data !== 8'hFF) begin
            bad++;
            $display("FAIL abort_word: valid=%b data=%h, required 1/ff", word_valid, word_data);
        end
        drain();
    endtask

    // Behavioural right-shift PISO: load a word, emit bit 0, shift right.
    task automatic test_loopback();
        logic [7:0] exp_q[$];
        logic [7:0] piso;
        logic [7:0] w;
        logic [7:0] exp_w;
        int         got;
        do_reset();
        word_ready = 1'b1;
        got        = 0;
        for (int n = 0; n < 512; n++) begin
            w    = 8'($urandom);
            piso = w;
            exp_q.push_back(w);
            for (int b = 0; b < 8; b++) begin
                while ($urandom_range(0, 3) == 0) begin
                    bit_valid = 1'b0;
                    serial_in = 1'($urandom);
                    tick();
                    if (word_valid) begin
                        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                        got++;
                        total++;
                        if (word_data !== exp_w) begin
                            bad++;
                            $display("FAIL loopback_word %0d: data=%h, required %h", got, word_data, exp_w);
                        end
                    end
                end
                bit_valid = 1'b1;
                serial_in = piso[0];
                piso      = {1'b0, piso[7:1]};
                tick();
                if (word_valid) begin
                    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    got++;
                    total++;
                    if (word_data !== exp_w) begin
                        bad++;
                        $display("FAIL loopback_word %0d: data=%h, required %h", got, word_data, exp_w);
                    end
                end
            end
        end
        bit_valid = 1'b0;
        tick();
        total++;
        if (got != 512 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL loopback_total: words=%0d ovr=%b, required 512/0", got, overrun);
        end
        word_ready = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        idle_inputs();
        test_reset();
        test_single_word();
        test_overrun();
        test_back_to_back();
        test_frame_start();
        test_reset_abort();
        test_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
